// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction fetch stage.
//   - fetch_state_t : fetch FSM encoding (IDLE, WAIT, HOLD, DROP)
//   - NOP_INSTR     : canonical RISC-V nop (addi x0,x0,0)
//   - DEFAULT_XLEN  : default address/data width
//   - pc_misaligned : true when a PC is not word aligned
package fetch_pkg;

  localparam int          DEFAULT_XLEN = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // sample PC, launch request
    WAIT = 2'd1,  // request outstanding
    HOLD = 2'd2,  // instruction presented to decode
    DROP = 2'd3   // flushed request still outstanding; swallow its ack
  } fetch_state_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return |pc_lo;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage between ProgramCounter and decode. Samples the PC, issues a
//   single outstanding word read over req/ack, presents the result to decode
//   over valid/ready and pulses the PC enable once per completed fetch.
//   All outputs come straight from registers.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   pc_in            current PC
//   pc_enable        one-cycle pulse advancing the PC
//   flush            discard current fetch (comes with a PC jump)
//   mem_req/addr     read request, held until mem_ack
//   mem_ack/rdata    read response
//   instr_valid      instr_out/instr_pc/instr_fault valid to decode
//   instr_ready      decode accepts on instr_valid & instr_ready
//   instr_out        fetched instruction (NOP when not valid)
//   instr_pc         address of instr_out
//   instr_fault      misaligned-PC fault
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          XLEN = DEFAULT_XLEN,
  parameter logic [31:0] NOP  = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_enable,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  fetch_state_t    r_state, w_state_nxt;

  logic            r_mem_req,     w_mem_req_nxt;
  logic [XLEN-1:0] r_mem_addr,    w_mem_addr_nxt;
  logic            r_pc_enable,   w_pc_enable_nxt;
  logic            r_instr_valid, w_instr_valid_nxt;
  logic            r_instr_fault, w_instr_fault_nxt;
  logic [31:0]     r_instr_out,   w_instr_out_nxt;
  logic [XLEN-1:0] r_instr_pc,    w_instr_pc_nxt;

  logic            w_misaligned;

  assign w_misaligned = pc_misaligned(pc_in[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_pc_enable_nxt   = 1'b0;        // pulse: only set on the WAIT->HOLD edge
    w_instr_valid_nxt = r_instr_valid;
    w_instr_fault_nxt = r_instr_fault;
    w_instr_out_nxt   = r_instr_out;
    w_instr_pc_nxt    = r_instr_pc;

    case (r_state)
      IDLE: begin
        if (!flush) begin
          if (w_misaligned) begin
            // Fault goes straight to decode; memory and PC are untouched.
            w_state_nxt       = HOLD;
            w_instr_valid_nxt = 1'b1;
            w_instr_fault_nxt = 1'b1;
            w_instr_out_nxt   = NOP;
            w_instr_pc_nxt    = pc_in;
          end else begin
            w_state_nxt    = WAIT;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = pc_in;
          end
        end
      end

      WAIT: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          if (flush) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt       = HOLD;
            w_instr_valid_nxt = 1'b1;
            w_instr_fault_nxt = 1'b0;
            w_instr_out_nxt   = mem_rdata;
            w_instr_pc_nxt    = r_mem_addr;
            w_pc_enable_nxt   = 1'b1;
          end
        end else if (flush) begin
          // Request cannot be withdrawn; keep mem_req up and eat the ack.
          w_state_nxt = DROP;
        end
      end

      DROP: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end

      HOLD: begin
        // Flush and handshake both retire the held slot; flush just means
        // the instruction was not consumed. Either way instr_out returns to
        // NOP and the fault flag clears along with valid.
        if (flush || instr_ready) begin
          w_state_nxt       = IDLE;
          w_instr_valid_nxt = 1'b0;
          w_instr_fault_nxt = 1'b0;
          w_instr_out_nxt   = NOP;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_pc_enable   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_fault <= 1'b0;
      r_instr_out   <= NOP;
      r_instr_pc    <= '0;
    end else begin
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_pc_enable   <= w_pc_enable_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr_fault <= w_instr_fault_nxt;
      r_instr_out   <= w_instr_out_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign pc_enable   = r_pc_enable;
  assign instr_valid = r_instr_valid;
  assign instr_fault = r_instr_fault;
  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
//   Bench for instruction_fetch: table of fetch vectors served by a
//   latency-programmable memory model, plus hand-written flush/reset
//   sequences. Expected decode outputs are queued when a fetch is launched
//   and compared while instr_valid is up; popped on handshake.
module tb_instruction_fetch;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_fault;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(32), .NOP(NOPW)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_enable(pc_enable),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_fault(instr_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          lat;
    int          rdly;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          n_pe     = 0;
  bit          checking = 0;
  bit          auto_mem = 1;
  int          mem_lat  = 0;
  int          wait_cnt = 0;
  logic [31:0] cur_rdata = '0;
  logic [31:0] exp_addr  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: compare outputs, retire a handshake, advance, then update
  // pulse counters and the memory model for the next cycle.
  task automatic tick();
    if (checking) begin
      if (instr_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", {31'b0, instr_valid}, 32'd0);
        end else begin
          chk("instr_out", instr_out, sbq[0].instr);
          chk("instr_pc", instr_pc, sbq[0].pc);
          chk("instr_fault", {31'b0, instr_fault}, {31'b0, sbq[0].fault});
          if (instr_ready && !flush) begin
            void'(sbq.pop_front());
            n_acc++;
          end
        end
      end else begin
        chk("nop_when_invalid", instr_out, NOPW);
      end
    end
    @(posedge clk); #1;
    if (checking) begin
      if (pc_enable === 1'b1) begin
        n_pe++;
        chk("pc_enable_in_hold", {31'b0, instr_valid}, 32'd1);
      end
      if (mem_req === 1'b1) chk("mem_addr", mem_addr, exp_addr);
    end
    if (auto_mem) begin
      if (mem_req !== 1'b1) begin
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_0000;
      end else begin
        mem_ack   = (wait_cnt == mem_lat);
        mem_rdata = mem_ack ? cur_rdata : 32'hBAD0_0000;
        wait_cnt++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int ticks = 0;
    int hold  = 0;
    int acc0  = n_acc;
    int pe0   = n_pe;
    int want;
    auto_mem  = 1;
    pc_in     = v.pc;
    cur_rdata = v.rdata;
    mem_lat   = v.lat;
    exp_addr  = v.pc;
    sbq.push_back('{instr: v.exp_instr, pc: v.pc, fault: v.exp_fault});
    while (n_acc == acc0 && ticks < 40) begin
      if (instr_valid === 1'b1) begin
        instr_ready = (hold >= v.rdly);
        hold++;
      end else begin
        instr_ready = 1'b0;
      end
      tick();
      ticks++;
    end
    instr_ready = 1'b0;
    want = v.exp_fault ? (2 + v.rdly) : (3 + v.lat + v.rdly);
    if (n_acc == acc0) $display("FAIL timeout: pc %h not accepted in 40 cycles", v.pc);
    chk("cycles_to_accept", ticks, want);
    chk("pc_enable_pulses", n_pe - pe0, v.exp_fault ? 0 : 1);
  endtask

  vec_t vecs[7];

  initial begin
    int pe0;
    int acc0;
    vecs[0] = '{32'h0000_0000, 32'h0010_0093, 0, 0, 32'h0010_0093, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0020_8113, 0, 0, 32'h0020_8113, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h0031_01b3, 0, 0, 32'h0031_01b3, 1'b0};
    vecs[3] = '{32'h0000_0010, 32'h0041_82b3, 3, 0, 32'h0041_82b3, 1'b0};
    vecs[4] = '{32'h0000_0014, 32'h0050_0093, 0, 5, 32'h0050_0093, 1'b0};
    vecs[5] = '{32'h0000_0006, 32'h1234_5678, 0, 0, NOPW,          1'b1};
    vecs[6] = '{32'h0000_0018, 32'h0000_006f, 1, 2, 32'h0000_006f, 1'b0};

    reset = 1'b1; pc_in = '0; flush = 1'b0; mem_ack = 1'b0;
    mem_rdata = '0; instr_ready = 1'b0;
    tick(); tick();
    chk("rst_mem_req",     {31'b0, mem_req},     32'd0);
    chk("rst_mem_addr",    mem_addr,             32'd0);
    chk("rst_pc_enable",   {31'b0, pc_enable},   32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr_fault", {31'b0, instr_fault}, 32'd0);
    chk("rst_instr_out",   instr_out,            NOPW);
    chk("rst_instr_pc",    instr_pc,             32'd0);
    reset = 1'b0;
    checking = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush in WAIT, ack arrives later through DROP.
    auto_mem = 0; mem_ack = 1'b0;
    pe0 = n_pe; acc0 = n_acc;
    pc_in = 32'h20; exp_addr = 32'h20;
    tick();
    chk("drop_req_up", {31'b0, mem_req}, 32'd1);
    flush = 1'b1;
    tick();                         // WAIT -> DROP
    chk("drop_req_held", {31'b0, mem_req}, 32'd1);
    pc_in = 32'h40;                 // jump target loaded
    tick();                         // DROP, flush again is ignored
    flush = 1'b0;
    chk("drop_req_held2", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();                         // DROP -> IDLE
    mem_ack = 1'b0;
    chk("drop_req_done", {31'b0, mem_req}, 32'd0);
    chk("drop_no_valid", {31'b0, instr_valid}, 32'd0);
    exp_addr = 32'h40;
    sbq.push_back('{instr: 32'h00A0_0113, pc: 32'h40, fault: 1'b0});
    tick();                         // IDLE -> WAIT at new PC
    chk("drop_new_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h00A0_0113;
    tick();
    mem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("drop_accepts", n_acc - acc0, 1);
    chk("drop_pe_once", n_pe - pe0, 1);

    // Flush coincident with ack in WAIT, then flush held in IDLE.
    pe0 = n_pe;
    pc_in = 32'h70; exp_addr = 32'h70;
    tick();
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("flush_ack_req", {31'b0, mem_req}, 32'd0);
    chk("flush_ack_valid", {31'b0, instr_valid}, 32'd0);
    tick();                         // flush in IDLE: no request
    flush = 1'b0;
    chk("flush_idle_noreq", {31'b0, mem_req}, 32'd0);
    chk("flush_ack_no_pe", n_pe - pe0, 0);

    // Flush in HOLD beats a same-cycle handshake.
    pe0 = n_pe; acc0 = n_acc;
    pc_in = 32'h60; exp_addr = 32'h60;
    sbq.push_back('{instr: 32'h0060_0193, pc: 32'h60, fault: 1'b0});
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0060_0193;
    tick();
    mem_ack = 1'b0;
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);
    flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0;
    chk("hold_flush_valid", {31'b0, instr_valid}, 32'd0);
    chk("hold_flush_noacc", n_acc - acc0, 0);
    chk("hold_flush_pe", n_pe - pe0, 1);
    if (sbq.size() > 0) void'(sbq.pop_front());

    // Reset while WAIT, then a stray ack while idle.
    acc0 = n_acc;
    pc_in = 32'h50; exp_addr = 32'h50;
    tick();
    chk("rst_wait_req", {31'b0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_wait_req0", {31'b0, mem_req}, 32'd0);
    chk("rst_wait_addr", mem_addr, 32'd0);
    chk("rst_wait_valid", {31'b0, instr_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
    pc_in = 32'h54; exp_addr = 32'h54;
    sbq.push_back('{instr: 32'h0070_0093, pc: 32'h54, fault: 1'b0});
    tick();                         // stray ack ignored, request issued
    chk("stray_no_valid", {31'b0, instr_valid}, 32'd0);
    chk("stray_req", {31'b0, mem_req}, 32'd1);
    mem_rdata = 32'h0070_0093;
    tick();
    mem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("stray_accepts", n_acc - acc0, 1);
    chk("sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
